// File: rtl/tmr_scrub_ctrl.sv
// TMR memory access controller: wait-stated CPU accesses with a bitwise majority vote,
// plus a background scrubber that rewrites disagreeing copies and keeps per-bank error counters.
module tmr_scrub_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 16,
  parameter int BANK_W    = 1,
  parameter int CNT_W     = 4,
  parameter int WAIT_CYC  = 2,
  parameter int SCRUB_DIV = 1024
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [BANK_W-1:0] cpu_bank,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic [BANK_W-1:0] mem_bank,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata0,
  input  logic [DATA_W-1:0] mem_rdata1,
  input  logic [DATA_W-1:0] mem_rdata2,
  input  logic              scrub_en,
  input  logic [BANK_W-1:0] cnt_sel,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_flag,
  output logic [BANK_W-1:0] scrub_bank,
  output logic [ADDR_W-1:0] scrub_addr,
  output logic              scrub_wrap
);

  localparam int NBANK  = 1 << BANK_W;
  localparam int PTR_W  = BANK_W + ADDR_W;
  localparam int WAIT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam int TMR_W  = $clog2(SCRUB_DIV);

  typedef enum logic [2:0] {IDLE, CPU_RD, CPU_WR, SCR_RD, SCR_WR, ACK} state_t;

  state_t            state, state_d;
  logic [WAIT_W-1:0] wcnt;
  logic [BANK_W-1:0] acc_bank;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [PTR_W-1:0]  ptr;
  logic [TMR_W-1:0]  timer;
  logic [CNT_W-1:0]  cnt_q [NBANK];
  logic [DATA_W-1:0] vote;
  logic              mismatch, last, start_cpu, start_scr, step_end, inc_en;

  assign vote     = (mem_rdata0 & mem_rdata1) | (mem_rdata1 & mem_rdata2) | (mem_rdata0 & mem_rdata2);
  assign mismatch = (mem_rdata0 != vote) || (mem_rdata1 != vote) || (mem_rdata2 != vote);
  assign last     = (wcnt == WAIT_W'(WAIT_CYC - 1));

  assign mem_re     = (state == CPU_RD) || (state == SCR_RD);
  assign mem_we     = (state == CPU_WR) || (state == SCR_WR);
  assign cpu_ack    = (state == ACK);
  assign mem_bank   = acc_bank;
  assign mem_addr   = acc_addr;
  assign mem_wdata  = acc_wdata;
  assign scrub_bank = ptr[PTR_W-1 -: BANK_W];
  assign scrub_addr = ptr[ADDR_W-1:0];
  assign err_cnt    = cnt_q[cnt_sel];

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_d;
  end

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d   = state;
    start_cpu = 1'b0;
    start_scr = 1'b0;
    step_end  = 1'b0;
    inc_en    = 1'b0;
    unique case (state)
      IDLE: begin
        if (cpu_req) begin
          start_cpu = 1'b1;
          state_d   = cpu_we ? CPU_WR : CPU_RD;
        end else if (scrub_en && timer == '0) begin
          start_scr = 1'b1;
          state_d   = SCR_RD;
        end
      end
      CPU_RD: if (last) begin
        state_d = ACK;
        inc_en  = mismatch;
      end
      CPU_WR: if (last) state_d = ACK;
      SCR_RD: if (last) begin
        if (mismatch) begin
          state_d = SCR_WR;
          inc_en  = 1'b1;
        end else begin
          state_d  = IDLE;
          step_end = 1'b1;
        end
      end
      SCR_WR: if (last) begin
        state_d  = IDLE;
        step_end = 1'b1;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wcnt       <= '0;
      acc_bank   <= '0;
      acc_addr   <= '0;
      acc_wdata  <= '0;
      ptr        <= '0;
      timer      <= TMR_W'(SCRUB_DIV - 1);
      cpu_rdata  <= '0;
      err_flag   <= 1'b0;
      scrub_wrap <= 1'b0;
    end else begin
      err_flag   <= inc_en;
      scrub_wrap <= step_end && (ptr == '1);

      if ((state inside {CPU_RD, CPU_WR, SCR_RD, SCR_WR}) && !last) wcnt <= wcnt + WAIT_W'(1);
      else                                                           wcnt <= '0;

      if (start_cpu) begin
        acc_bank  <= cpu_bank;
        acc_addr  <= cpu_addr;
        acc_wdata <= cpu_wdata;
      end else if (start_scr) begin
        {acc_bank, acc_addr} <= ptr;
      end else if (state == SCR_RD && last) begin
        acc_wdata <= vote;
      end

      if (state == CPU_RD && last) cpu_rdata <= vote;

      // Pointer increment carries from address into bank and wraps to zero naturally.
      if (step_end) begin
        ptr   <= ptr + PTR_W'(1);
        timer <= TMR_W'(SCRUB_DIV - 1);
      end else if (state == IDLE && scrub_en && timer != '0) begin
        timer <= timer - TMR_W'(1);
      end
    end
  end

  // NOTE: the counter array is a handful of flops read by the CPU, so it is reset explicitly.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int b = 0; b < NBANK; b++) cnt_q[b] <= '0;
    end else begin
      for (int b = 0; b < NBANK; b++) begin
        if (cnt_clr && cnt_sel == BANK_W'(b))
          cnt_q[b] <= (inc_en && acc_bank == BANK_W'(b)) ? CNT_W'(1) : '0;
        else if (inc_en && acc_bank == BANK_W'(b) && cnt_q[b] != '1)
          cnt_q[b] <= cnt_q[b] + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Bench for tmr_scrub_ctrl: a small-geometry instance checked every cycle against an access-level
// model over a TMR memory, plus a default-geometry instance with hand-computed cycle expectations.
module tb_tmr_scrub_ctrl;

  localparam int W    = 2;
  localparam int DIV  = 4;
  localparam int NLOC = 32;

  logic CLK, RESET;
  int   n_checks = 0;
  int   n_errors = 0;

  // Instance B: ADDR_W=4, SCRUB_DIV=4
  logic       b_req, b_we, b_bank, b_ack, b_mbank, b_mre, b_mwe, b_scrub_en, b_cnt_sel, b_cnt_clr;
  logic       b_err_flag, b_sbank, b_swrap;
  logic [3:0] b_addr, b_maddr, b_saddr, b_err_cnt;
  logic [7:0] b_wdata, b_rdata, b_mwdata, b_r0, b_r1, b_r2;

  // Instance A: default geometry
  logic        a_req, a_we, a_bank, a_ack, a_mbank, a_mre, a_mwe, a_scrub_en, a_cnt_sel, a_cnt_clr;
  logic        a_err_flag, a_sbank, a_swrap;
  logic [15:0] a_addr, a_maddr, a_saddr;
  logic [3:0]  a_err_cnt;
  logic [7:0]  a_wdata, a_rdata, a_mwdata, a_r0, a_r1, a_r2;

  tmr_scrub_ctrl #(.DATA_W(8), .ADDR_W(4), .BANK_W(1), .CNT_W(4), .WAIT_CYC(W), .SCRUB_DIV(DIV)) dut_b (
    .CLK(CLK), .RESET(RESET), .cpu_req(b_req), .cpu_we(b_we), .cpu_bank(b_bank), .cpu_addr(b_addr),
    .cpu_wdata(b_wdata), .cpu_rdata(b_rdata), .cpu_ack(b_ack), .mem_bank(b_mbank), .mem_addr(b_maddr),
    .mem_re(b_mre), .mem_we(b_mwe), .mem_wdata(b_mwdata), .mem_rdata0(b_r0), .mem_rdata1(b_r1),
    .mem_rdata2(b_r2), .scrub_en(b_scrub_en), .cnt_sel(b_cnt_sel), .cnt_clr(b_cnt_clr),
    .err_cnt(b_err_cnt), .err_flag(b_err_flag), .scrub_bank(b_sbank), .scrub_addr(b_saddr),
    .scrub_wrap(b_swrap));

  tmr_scrub_ctrl #(.DATA_W(8), .ADDR_W(16), .BANK_W(1), .CNT_W(4), .WAIT_CYC(2), .SCRUB_DIV(1024)) dut_a (
    .CLK(CLK), .RESET(RESET), .cpu_req(a_req), .cpu_we(a_we), .cpu_bank(a_bank), .cpu_addr(a_addr),
    .cpu_wdata(a_wdata), .cpu_rdata(a_rdata), .cpu_ack(a_ack), .mem_bank(a_mbank), .mem_addr(a_maddr),
    .mem_re(a_mre), .mem_we(a_mwe), .mem_wdata(a_mwdata), .mem_rdata0(a_r0), .mem_rdata1(a_r1),
    .mem_rdata2(a_r2), .scrub_en(a_scrub_en), .cnt_sel(a_cnt_sel), .cnt_clr(a_cnt_clr),
    .err_cnt(a_err_cnt), .err_flag(a_err_flag), .scrub_bank(a_sbank), .scrub_addr(a_saddr),
    .scrub_wrap(a_swrap));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- triple-copy memory behind instance B ----------------
  logic [7:0] mem0 [NLOC];
  logic [7:0] mem1 [NLOC];
  logic [7:0] mem2 [NLOC];
  logic       mem_fill, poke_en;
  logic [4:0] poke_idx;
  logic [7:0] poke_v0, poke_v1, poke_v2;

  assign b_r0 = mem0[{b_mbank, b_maddr}];
  assign b_r1 = mem1[{b_mbank, b_maddr}];
  assign b_r2 = mem2[{b_mbank, b_maddr}];

  always @(posedge CLK) begin
    if (mem_fill) begin
      for (int i = 0; i < NLOC; i++) begin
        mem0[i] <= 8'(i * 5 + 3);
        mem1[i] <= 8'(i * 5 + 3);
        mem2[i] <= 8'(i * 5 + 3);
      end
    end else begin
      if (b_mwe) begin
        mem0[{b_mbank, b_maddr}] <= b_mwdata;
        mem1[{b_mbank, b_maddr}] <= b_mwdata;
        mem2[{b_mbank, b_maddr}] <= b_mwdata;
      end
      if (poke_en) begin
        mem0[poke_idx] <= poke_v0;
        mem1[poke_idx] <= poke_v1;
        mem2[poke_idx] <= poke_v2;
      end
    end
  end

  // ---------------- access-level model of instance B ----------------
  typedef enum {OP_NONE, OP_RD, OP_WR, OP_SCR} op_t;
  op_t        m_op = OP_NONE;
  int         m_k, m_bank, m_addr, m_ptr, m_timer;
  int         m_cnt [2];
  bit         m_fix, m_flag, m_wrap;
  logic [7:0] m_wdata, m_rdata;

  function automatic logic [7:0] majority(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = (int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2;
    return v;
  endfunction

  always @(posedge CLK) begin
    int idx, ib;
    bit inc, done;
    logic [7:0] v;
    inc  = 1'b0;
    ib   = 0;
    done = 1'b0;
    if (RESET) begin
      m_op = OP_NONE; m_k = 0; m_fix = 0; m_bank = 0; m_addr = 0; m_wdata = '0;
      m_ptr = 0; m_timer = DIV - 1; m_cnt[0] = 0; m_cnt[1] = 0;
      m_rdata = '0; m_flag = 0; m_wrap = 0;
    end else begin
      m_wrap = 0;
      idx = m_bank * 16 + m_addr;
      case (m_op)
        OP_NONE: begin
          if (b_req) begin
            m_op = b_we ? OP_WR : OP_RD; m_k = 1; m_fix = 0;
            m_bank = int'(b_bank); m_addr = int'(b_addr); m_wdata = b_wdata;
          end else if (b_scrub_en && m_timer == 0) begin
            m_op = OP_SCR; m_k = 1; m_fix = 0; m_bank = m_ptr / 16; m_addr = m_ptr % 16;
          end
          if (b_scrub_en && m_timer > 0) m_timer--;
        end
        OP_RD, OP_WR: begin
          if (m_k == W) begin
            if (m_op == OP_RD) begin
              m_rdata = majority(mem0[idx], mem1[idx], mem2[idx]);
              if (!(mem0[idx] == mem1[idx] && mem1[idx] == mem2[idx])) begin inc = 1; ib = m_bank; end
            end
            m_k++;
          end else if (m_k == W + 1) m_op = OP_NONE;
          else m_k++;
        end
        OP_SCR: begin
          if (m_k == W && !m_fix) begin
            v = majority(mem0[idx], mem1[idx], mem2[idx]);
            if (!(mem0[idx] == mem1[idx] && mem1[idx] == mem2[idx])) begin
              m_fix = 1; m_wdata = v; inc = 1; ib = m_bank; m_k++;
            end else done = 1;
          end else if (m_k == 2 * W) done = 1;
          else m_k++;
          if (done) begin
            m_op = OP_NONE; m_timer = DIV - 1;
            if (m_ptr == NLOC - 1) begin m_ptr = 0; m_wrap = 1; end
            else m_ptr++;
          end
        end
        default: m_op = OP_NONE;
      endcase
      for (int b = 0; b < 2; b++) begin
        if (b_cnt_clr && int'(b_cnt_sel) == b) m_cnt[b] = (inc && ib == b) ? 1 : 0;
        else if (inc && ib == b && m_cnt[b] < 15) m_cnt[b]++;
      end
      m_flag = inc;
    end
  end

  // ---------------- per-cycle compare of instance B ----------------
  bit cmp_en = 0;
  always @(posedge CLK) begin
    bit e_re, e_we, e_ack;
    #1;
    if (cmp_en) begin
      e_re  = (m_op == OP_RD || m_op == OP_SCR) && m_k <= W;
      e_we  = (m_op == OP_WR && m_k <= W) || (m_op == OP_SCR && m_k > W);
      e_ack = (m_op == OP_RD || m_op == OP_WR) && m_k == W + 1;
      check("mem_re", b_mre, e_re);
      check("mem_we", b_mwe, e_we);
      check("cpu_ack", b_ack, e_ack);
      if (e_re || e_we) check("mem_loc", {b_mbank, b_maddr}, m_bank * 16 + m_addr);
      if (e_we) check("mem_wdata", b_mwdata, m_wdata);
      check("cpu_rdata", b_rdata, m_rdata);
      check("err_flag", b_err_flag, m_flag);
      check("scrub_wrap", b_swrap, m_wrap);
      check("scrub_ptr", {b_sbank, b_saddr}, m_ptr);
      check("err_cnt", b_err_cnt, m_cnt[b_cnt_sel]);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Caller is at a negedge; raises req now, waits for ack, pulses cnt_clr in cycle clr_at.
  task automatic cpu_op(input bit w, input logic bk, input logic [3:0] ad, input logic [7:0] d,
                        input int clr_at, output int lat);
    b_req = 1; b_we = w; b_bank = bk; b_addr = ad; b_wdata = d;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      b_cnt_clr = (i == clr_at);
      if (b_ack) begin lat = i; break; end
    end
    b_req = 0; b_cnt_clr = 0;
    if (lat < 0) check("ack_timeout", 0, 1);
  endtask

  task automatic poke(input int idx, input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2);
    poke_en = 1; poke_idx = 5'(idx); poke_v0 = v0; poke_v1 = v1; poke_v2 = v2;
    @(negedge CLK);
    poke_en = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, steps, flags, cyc;
    bit prev_re, seen;
    RESET = 1; mem_fill = 1; poke_en = 0; poke_idx = '0; poke_v0 = '0; poke_v1 = '0; poke_v2 = '0;
    b_req = 0; b_we = 0; b_bank = 0; b_addr = '0; b_wdata = '0;
    b_scrub_en = 0; b_cnt_sel = 0; b_cnt_clr = 0;
    a_req = 0; a_we = 0; a_bank = 0; a_addr = '0; a_wdata = '0;
    a_scrub_en = 0; a_cnt_sel = 0; a_cnt_clr = 0;
    a_r0 = 8'hA5; a_r1 = 8'hA5; a_r2 = 8'h25;
    repeat (3) @(negedge CLK);
    mem_fill = 0;
    poke(19, 8'h3C, 8'h3C, 8'h00);
    cmp_en = 1;
    RESET = 0;
    @(negedge CLK);

    // Reset state, both instances
    check("rst_b_outputs", {b_mre, b_mwe, b_ack, b_err_flag, b_swrap, b_sbank, b_mbank}, 0);
    check("rst_b_words", {b_rdata, b_mwdata, b_saddr, b_maddr, b_err_cnt}, 0);
    check("rst_a_outputs", {a_mre, a_mwe, a_ack, a_err_flag, a_swrap, a_sbank, a_mbank}, 0);
    check("rst_a_words", {a_rdata, a_mwdata, a_err_cnt}, 0);
    check("rst_a_addr", {a_saddr, a_maddr}, 0);

    // Default geometry: write 0xA5 to bank0/0x0010
    a_req = 1; a_we = 1; a_addr = 16'h0010; a_wdata = 8'hA5;
    for (int c = 1; c <= 3; c++) begin
      @(negedge CLK);
      check("t1_mem_we", a_mwe, c <= 2);
      check("t1_cpu_ack", a_ack, c == 3);
      if (c <= 2) check("t1_mem_wdata", a_mwdata, 8'hA5);
      if (c <= 2) check("t1_mem_addr", a_maddr, 16'h0010);
    end
    a_req = 0;
    @(negedge CLK);

    // Default geometry: read with copies A5/A5/25
    a_req = 1; a_we = 0; a_addr = 16'h0010;
    for (int c = 1; c <= 4; c++) begin
      @(negedge CLK);
      if (c == 3) a_req = 0;
      check("t2_mem_re", a_mre, c <= 2);
      check("t2_cpu_ack", a_ack, c == 3);
      check("t2_err_flag", a_err_flag, c == 3);
      if (c == 3) check("t2_cpu_rdata", a_rdata, 8'hA5);
      if (c >= 3) check("t2_err_cnt", a_err_cnt, 1);
    end

    // Scrub sweep on the small geometry: one bad copy at bank1/addr3
    b_scrub_en = 1;
    steps = 0; flags = 0; prev_re = 0; seen = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge CLK);
      if (b_mre && !prev_re) steps++;
      prev_re = b_mre;
      if (b_err_flag) flags++;
      if (b_swrap) begin seen = 1; break; end
    end
    b_scrub_en = 0;
    check("t3_wrap_seen", seen, 1);
    check("t3_steps_to_wrap", steps, 32);
    check("t3_err_pulses", flags, 1);
    check("t3_copy2_repaired", mem2[19], 8'h3C);
    check("t3_wrap_ptr", {b_sbank, b_saddr}, 0);
    b_cnt_sel = 1;
    @(negedge CLK);
    check("t3_cnt_bank1", b_err_cnt, 1);
    b_cnt_sel = 0;
    @(negedge CLK);
    check("t3_cnt_bank0", b_err_cnt, 0);

    // 17 mismatching CPU reads saturate the bank0 counter
    poke(5, 8'h1C, 8'hFF, 8'h1C);
    for (int n = 0; n < 17; n++) begin
      cpu_op(0, 0, 4'd5, 8'h00, -1, lat);
      if (n == 0) check("t4_read_latency", lat, W + 1);
      check("t4_voted_rdata", b_rdata, 8'h1C);
      @(negedge CLK);
    end
    check("t4_cnt_saturated", b_err_cnt, 15);
    cpu_op(0, 0, 4'd5, 8'h00, W, lat);
    check("t4_clr_with_inc", b_err_cnt, 1);
    @(negedge CLK);
    b_cnt_sel = 1; b_cnt_clr = 1;
    @(negedge CLK);
    b_cnt_clr = 0;
    check("t4_cnt1_cleared", b_err_cnt, 0);
    b_cnt_sel = 0;
    @(negedge CLK);
    check("t4_cnt0_kept", b_err_cnt, 1);

    // CPU request in the same cycle the scrub timer reaches zero
    b_scrub_en = 1;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (m_op == OP_NONE && m_timer == 0) begin seen = 1; break; end
    end
    check("t5_timer_reached", seen, 1);
    cpu_op(1, 1, 4'd0, 8'h77, -1, lat);
    check("t5_cpu_first", lat, W + 1);
    @(negedge CLK);
    check("t5_gap_re", b_mre, 0);
    @(negedge CLK);
    check("t5_scrub_re", b_mre, 1);
    check("t5_scrub_loc", {b_mbank, b_maddr}, 0);

    // Reset in the middle of a scrub write-back
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (m_op == OP_NONE) begin seen = 1; break; end
    end
    check("t6_step_done", seen, 1);
    poke(m_ptr, mem0[m_ptr] ^ 8'hFF, mem1[m_ptr], mem2[m_ptr]);
    seen = 0;
    cyc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (b_mwe) begin seen = 1; break; end
    end
    check("t6_scr_wr_reached", seen, 1);
    RESET = 1;
    @(negedge CLK);
    check("t6_mem_we", b_mwe, 0);
    check("t6_mem_re", b_mre, 0);
    check("t6_scrub_ptr", {b_sbank, b_saddr}, 0);
    check("t6_cnt0", b_err_cnt, 0);
    b_cnt_sel = 1;
    @(negedge CLK);
    check("t6_cnt1", b_err_cnt, 0);
    RESET = 0;
    b_cnt_sel = 0;
    repeat (12) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
